// File: rtl/dds_pkg.sv
// Shared widths, waveform encoding and sequencer state type for the DDS datapath.
package dds_pkg;

    localparam int PHASE_W_DEF = 24;
    localparam int ADDR_W_DEF  = 10;
    localparam int N_WAVE_DEF  = 4;

    typedef enum logic [1:0] {SINE, SQUARE, TRI, SAW} wave_t;

    typedef enum logic {WAIT_RDY, RUN} seq_state_t;

    // Round-robin step through the first n_wave waveforms.
    function automatic wave_t next_wave(input wave_t cur, input int n_wave);
        logic [1:0] step;
        step = cur;
        if (int'(step) >= n_wave - 1) begin
            return SINE;
        end
        step = step + 2'd1;
        return wave_t'(step);
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator: adds the increment on enable, clears synchronously,
// and exposes the next phase and carry-out combinationally for the caller.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int W = PHASE_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] inc,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] phase_q;
    logic [W-1:0] phase_d;
    logic [W:0]   sum_full;

    always_comb begin
        sum_full = {1'b0, phase_q} + {1'b0, inc};
        phase_d  = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = sum_full[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign sum   = sum_full[W-1:0];
    assign carry = sum_full[W];

endmodule

// File: rtl/dds_wave_sequencer.sv
// DDS sequencer: run/wait FSM, pending tuning-word and waveform requests applied at
// phase wrap, and the DAC valid/ack handshake.
module dds_wave_sequencer
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int N_WAVE  = N_WAVE_DEF
) (
    input  logic               Fg_CLK,
    input  logic               RESETn,
    input  logic               Ready,
    input  logic               SampEn,
    input  logic               WaveBTN,
    input  logic               FreqWr,
    input  logic [PHASE_W-1:0] FreqWord,
    output logic [ADDR_W-1:0]  RomAddr,
    output logic [1:0]         WaveSel,
    output logic               DacValid,
    input  logic               DacAck,
    output logic               Overrun,
    output logic               Running
);

    // DAC handshake: DacValid rises with each accepted sample and stays high until a cycle
    // with DacAck=1; a sample is accepted only when the DAC slot is free or being acked.
    seq_state_t         state_q, state_d;
    logic [PHASE_W-1:0] active_tw_q, active_tw_d;
    logic [PHASE_W-1:0] pend_tw_q, pend_tw_d;
    logic               pend_tw_v_q, pend_tw_v_d;
    logic               wave_req_q, wave_req_d;
    wave_t              wave_sel_q, wave_sel_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               dac_valid_q, dac_valid_d;
    logic               overrun_q, overrun_d;

    logic               stay, leave, accept, apply, carry;
    logic [PHASE_W-1:0] sum;

    dds_phase_acc #(.W(PHASE_W)) u_acc (
        .clk   (Fg_CLK),
        .rst_n (RESETn),
        .en    (accept),
        .clr   (leave),
        .inc   (active_tw_q),
        .sum   (sum),
        .carry (carry)
    );

    always_comb begin
        stay        = (state_q == RUN) && Ready;
        leave       = (state_q == RUN) && !Ready;
        accept      = stay && SampEn && (!dac_valid_q || DacAck);
        apply       = accept && (carry || (active_tw_q == '0));

        state_d     = state_q;
        active_tw_d = active_tw_q;
        pend_tw_d   = pend_tw_q;
        pend_tw_v_d = pend_tw_v_q;
        wave_req_d  = wave_req_q;
        wave_sel_d  = wave_sel_q;
        rom_addr_d  = rom_addr_q;
        dac_valid_d = dac_valid_q;
        overrun_d   = stay && SampEn && dac_valid_q && !DacAck;

        case (state_q)
            WAIT_RDY: if (Ready)  state_d = RUN;
            RUN:      if (!Ready) state_d = WAIT_RDY;
            default:  state_d = WAIT_RDY;
        endcase

        if (leave) begin
            dac_valid_d = 1'b0;
        end else if (accept) begin
            dac_valid_d = 1'b1;
            rom_addr_d  = sum[PHASE_W-1 -: ADDR_W];
        end else if (stay && DacAck) begin
            dac_valid_d = 1'b0;
        end

        // The sample on the apply edge still uses the old active_tw (it feeds the adder).
        if (apply && pend_tw_v_q) begin
            active_tw_d = pend_tw_q;
            pend_tw_v_d = 1'b0;
        end
        if (apply && wave_req_q) begin
            wave_sel_d = next_wave(wave_sel_q, N_WAVE);
            wave_req_d = 1'b0;
        end

        // New requests arriving on an apply edge win over the clear and wait for the next wrap.
        if (FreqWr) begin
            pend_tw_d   = FreqWord;
            pend_tw_v_d = 1'b1;
        end
        if (stay && WaveBTN) begin
            wave_req_d = 1'b1;
        end
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= WAIT_RDY;
            active_tw_q <= '0;
            pend_tw_q   <= '0;
            pend_tw_v_q <= 1'b0;
            wave_req_q  <= 1'b0;
            wave_sel_q  <= SINE;
            rom_addr_q  <= '0;
            dac_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_tw_q <= active_tw_d;
            pend_tw_q   <= pend_tw_d;
            pend_tw_v_q <= pend_tw_v_d;
            wave_req_q  <= wave_req_d;
            wave_sel_q  <= wave_sel_d;
            rom_addr_q  <= rom_addr_d;
            dac_valid_q <= dac_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign RomAddr  = rom_addr_q;
    assign WaveSel  = wave_sel_q;
    assign DacValid = dac_valid_q;
    assign Overrun  = overrun_q;
    assign Running  = (state_q == RUN);

endmodule

// File: tb/tb_dds_wave_sequencer.sv
// Bench for dds_wave_sequencer: directed vector table, async-reset check, then random
// stimulus against an arithmetic reference model.
module tb_dds_wave_sequencer;

    logic        Fg_CLK = 1'b0;
    logic        RESETn;
    logic        Ready, SampEn, WaveBTN, FreqWr, DacAck;
    logic [23:0] FreqWord;
    logic [9:0]  RomAddr;
    logic [1:0]  WaveSel;
    logic        DacValid, Overrun, Running;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Fg_CLK = ~Fg_CLK;

    dds_wave_sequencer dut (
        .Fg_CLK   (Fg_CLK),
        .RESETn   (RESETn),
        .Ready    (Ready),
        .SampEn   (SampEn),
        .WaveBTN  (WaveBTN),
        .FreqWr   (FreqWr),
        .FreqWord (FreqWord),
        .RomAddr  (RomAddr),
        .WaveSel  (WaveSel),
        .DacValid (DacValid),
        .DacAck   (DacAck),
        .Overrun  (Overrun),
        .Running  (Running)
    );

    typedef struct {
        logic        rdy, samp, btn, fwr;
        logic [23:0] fword;
        logic        ack;
        logic [9:0]  addr;
        logic        valid;
        logic [1:0]  sel;
        logic        ovr, run;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, samp, btn, fwr, input logic [23:0] fword,
                                input logic ack, input logic [9:0] addr, input logic valid,
                                input logic [1:0] sel, input logic ovr, run);
        vec_t v;
        v.rdy = rdy; v.samp = samp; v.btn = btn; v.fwr = fwr; v.fword = fword; v.ack = ack;
        v.addr = addr; v.valid = valid; v.sel = sel; v.ovr = ovr; v.run = run;
        return v;
    endfunction

    // Packed observation: {RomAddr, DacValid, WaveSel, Overrun, Running}
    function automatic logic [14:0] pack(input logic [9:0] a, input logic v, input logic [1:0] s,
                                         input logic o, input logic r);
        return {a, v, s, o, r};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got addr=%h valid=%b sel=%0d ovr=%b run=%b, want addr=%h valid=%b sel=%0d ovr=%b run=%b",
                     name, act[14:5], act[4], act[3:2], act[1], act[0],
                     exp[14:5], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic rdy, samp, btn, fwr, input logic [23:0] fword, input logic ack);
        Ready = rdy; SampEn = samp; WaveBTN = btn; FreqWr = fwr; FreqWord = fword; DacAck = ack;
    endtask

    // Reference model: state kept as plain numbers, updated from the behavioural rules.
    logic        m_run, m_pv, m_wreq, m_valid, m_ovr;
    longint      m_phase, m_tw, m_ptw;
    int          m_sel;
    logic [9:0]  m_addr;

    task automatic model_reset();
        m_run = 0; m_pv = 0; m_wreq = 0; m_valid = 0; m_ovr = 0;
        m_phase = 0; m_tw = 0; m_ptw = 0; m_sel = 0; m_addr = '0;
    endtask

    task automatic model_step(input logic rdy, samp, btn, fwr, input logic [23:0] fword, input logic ack);
        longint s;
        logic   wrapped;
        m_ovr = 0;
        if (!m_run) begin
            if (rdy) m_run = 1;
        end else if (!rdy) begin
            m_run = 0; m_phase = 0; m_valid = 0;
        end else begin
            if (samp && (!m_valid || ack)) begin
                s       = m_phase + m_tw;
                wrapped = (s >= 64'h100_0000);
                m_phase = s % 64'h100_0000;
                m_addr  = 10'(m_phase / 16384);
                m_valid = 1;
                if (wrapped || m_tw == 0) begin
                    if (m_pv)   begin m_tw = m_ptw; m_pv = 0; end
                    if (m_wreq) begin m_sel = (m_sel + 1) % 4; m_wreq = 0; end
                end
            end else begin
                if (samp && m_valid && !ack) m_ovr = 1;
                if (ack) m_valid = 0;
            end
            if (btn) m_wreq = 1;
        end
        if (fwr) begin m_ptw = fword; m_pv = 1; end
    endtask

    initial begin
        logic [23:0] fw;
        drive(0, 0, 0, 0, 24'h0, 0);
        RESETn = 1'b0;
        repeat (3) @(posedge Fg_CLK);
        #1;
        check("reset", pack(RomAddr, DacValid, WaveSel, Overrun, Running), 15'h0);
        @(negedge Fg_CLK);
        RESETn = 1'b1;

        //            rdy s  b  fw fword       ack addr    v  sel ovr run
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      0, 10'h000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 24'h400000, 0, 10'h000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h000, 1, 0, 0, 1)); // tw=0: apply, frozen
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h100, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h200, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h300, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h000, 1, 0, 0, 1)); // wrap
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      1, 10'h000, 0, 0, 0, 1)); // ack clears valid
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      0, 10'h100, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      0, 10'h100, 1, 0, 1, 1)); // dropped
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      0, 10'h100, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      1, 10'h100, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 24'h0,      0, 10'h100, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 24'h0,      0, 10'h100, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h200, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 24'h0,      0, 10'h200, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h300, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h000, 1, 1, 0, 1)); // wrap: sel 0->1 once
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h100, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 24'h200000, 1, 10'h100, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h200, 1, 1, 0, 1)); // old step kept
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h300, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h000, 1, 1, 0, 1)); // carry: new tw applied
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h080, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h100, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      1, 10'h180, 1, 1, 0, 1)); // phase 0x600000
        vecs.push_back(mk(0, 1, 0, 0, 24'h0,      0, 10'h180, 0, 1, 0, 0)); // Ready drop wins
        vecs.push_back(mk(0, 1, 0, 0, 24'h0,      0, 10'h180, 0, 1, 0, 0)); // SampEn ignored
        vecs.push_back(mk(1, 0, 0, 0, 24'h0,      0, 10'h180, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 24'h0,      0, 10'h080, 1, 1, 0, 1)); // phase restarted at 0

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].samp, vecs[i].btn, vecs[i].fwr, vecs[i].fword, vecs[i].ack);
            @(posedge Fg_CLK);
            #1;
            check($sformatf("vec%0d", i), pack(RomAddr, DacValid, WaveSel, Overrun, Running),
                  pack(vecs[i].addr, vecs[i].valid, vecs[i].sel, vecs[i].ovr, vecs[i].run));
            @(negedge Fg_CLK);
        end

        // Asynchronous reset mid-transfer: outputs clear without waiting for a clock edge.
        drive(1, 0, 0, 0, 24'h0, 0);
        @(posedge Fg_CLK);
        #2;
        RESETn = 1'b0;
        #1;
        check("async_reset", pack(RomAddr, DacValid, WaveSel, Overrun, Running), 15'h0);
        @(negedge Fg_CLK);
        RESETn = 1'b1;
        model_reset();

        for (int c = 0; c < 4000; c++) begin
            logic rdy, samp, btn, fwr, ack;
            rdy  = ($urandom_range(0, 15) != 0);
            samp = ($urandom_range(0, 2) == 0);
            btn  = ($urandom_range(0, 9) == 0);
            fwr  = ($urandom_range(0, 24) == 0);
            ack  = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 6))
                0: fw = 24'h400000;
                1: fw = 24'h800000;
                2: fw = 24'h555555;
                3: fw = 24'hFFFFFF;
                4: fw = 24'h0;
                5: fw = 24'h100000;
                default: fw = 24'($urandom);
            endcase
            drive(rdy, samp, btn, fwr, fw, ack);
            model_step(rdy, samp, btn, fwr, fw, ack);
            @(posedge Fg_CLK);
            #1;
            check($sformatf("rand%0d", c), pack(RomAddr, DacValid, WaveSel, Overrun, Running),
                  pack(m_addr, m_valid, 2'(m_sel), m_ovr, m_run));
            @(negedge Fg_CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
